// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection and forwarding-select generation for
// the instruction sitting in ID. A shadow pipeline of destination tags,
// DEPTH entries deep, mirrors the in-flight instructions after ID.
// Entry 0 is EXE and entry DEPTH-1 is the last stage before register-file write.
// FWD_EN=0 stalls on any RAW match. FWD_EN=1 forwards from the youngest
// matching entry and stalls only on a load-use hazard against entry 0.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 2,
  parameter bit FWD_EN     = 1'b0,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] src_1,
  input  logic [REG_ADDR_W-1:0] src_2,
  input  logic                  two_src,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic [SEL_W-1:0]      fwd_sel_1,
  output logic [SEL_W-1:0]      fwd_sel_2,
  output logic [15:0]           stall_count
);

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_wb_en;
  logic [DEPTH-1:0]      ent_mem_read;
  logic [REG_ADDR_W-1:0] ent_dest [DEPTH];

  logic [DEPTH-1:0] match_1;
  logic [DEPTH-1:0] match_2;
  logic             load_use;
  logic             raw_any;
  logic             issue;
  logic [SEL_W-1:0] pick_1;
  logic [SEL_W-1:0] pick_2;

  // Per-entry source matches; src_2 only counts when the instruction reads it.
  always_comb begin
    match_1 = '0;
    match_2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_1[k] = ent_valid[k] & ent_wb_en[k] & (ent_dest[k] == src_1);
      match_2[k] = two_src & ent_valid[k] & ent_wb_en[k] & (ent_dest[k] == src_2);
    end
  end

  // Stall decision. Both hazard kinds are always computed so that each
  // configuration uses the full entry state; FWD_EN picks which one stalls.
  always_comb begin
    load_use        = ent_mem_read[0] & (match_1[0] | match_2[0]);
    raw_any         = (|match_1) | (|match_2);
    hazard_detected = id_valid & (FWD_EN ? load_use : raw_any);
    issue           = id_valid & ~hazard_detected & ~flush;
  end

  // Forwarding selects: the youngest (lowest-index) matching entry wins, so
  // the search runs from the oldest entry down and lets younger hits overwrite.
  always_comb begin
    pick_1 = '0;
    pick_2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_1[k]) pick_1 = SEL_W'(k + 1);
      if (match_2[k]) pick_2 = SEL_W'(k + 1);
    end
    fwd_sel_1 = (FWD_EN && id_valid) ? pick_1 : '0;
    fwd_sel_2 = (FWD_EN && id_valid) ? pick_2 : '0;
  end

  // Shadow pipeline: advance every clock and load either the issued ID
  // instruction or a bubble into entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid    <= '0;
      ent_wb_en    <= '0;
      ent_mem_read <= '0;
      for (int k = 0; k < DEPTH; k++) ent_dest[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_valid[k]    <= ent_valid[k-1];
        ent_wb_en[k]    <= ent_wb_en[k-1];
        ent_mem_read[k] <= ent_mem_read[k-1];
        ent_dest[k]     <= ent_dest[k-1];
      end
      ent_valid[0]    <= issue;
      ent_wb_en[0]    <= issue & id_wb_en;
      ent_mem_read[0] <= issue & id_mem_read;
      ent_dest[0]     <= issue ? id_dest : '0;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (hazard_detected && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances share one stimulus stream
// (FWD_EN=0/DEPTH=2, FWD_EN=1/DEPTH=2, FWD_EN=0/DEPTH=8). A directed vector
// table, a reset-in-stall sequence, random traffic and a counter saturation
// run are checked against an in-bench model of in-flight instructions.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, two_src, id_wb_en, id_mem_read, flush;
  logic [3:0] src_1, src_2, id_dest;

  logic        haz_0, haz_1, haz_2;
  logic [1:0]  f1_0, f2_0, f1_1, f2_1;
  logic [3:0]  f1_2, f2_2;
  logic [15:0] cnt_0, cnt_1, cnt_2;

  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(2), .FWD_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_1(src_1), .src_2(src_2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .flush(flush), .hazard_detected(haz_0),
    .fwd_sel_1(f1_0), .fwd_sel_2(f2_0), .stall_count(cnt_0));

  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(2), .FWD_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_1(src_1), .src_2(src_2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .flush(flush), .hazard_detected(haz_1),
    .fwd_sel_1(f1_1), .fwd_sel_2(f2_1), .stall_count(cnt_1));

  hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(8), .FWD_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_1(src_1), .src_2(src_2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .flush(flush), .hazard_detected(haz_2),
    .fwd_sel_1(f1_2), .fwd_sel_2(f2_2), .stall_count(cnt_2));

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int dep [3] = '{2, 2, 8};
  bit fen [3] = '{1'b0, 1'b1, 1'b0};

  // Each slot holds the instruction that entered EXE k cycles ago (age k).
  logic       mv [3][8];
  logic       mw [3][8];
  logic       mm [3][8];
  logic [3:0] md [3][8];
  int         mcnt [3];
  int         raw2;
  logic       mh  [3];
  int         mf1 [3];
  int         mf2 [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 8; k++) begin
        mv[i][k] = 0; mw[i][k] = 0; mm[i][k] = 0; md[i][k] = 0;
      end
      mcnt[i] = 0;
    end
    raw2 = 0;
  endfunction

  function automatic void model_eval();
    for (int i = 0; i < 3; i++) begin
      int  p1, p2;
      bit  any, lu, h1, h2;
      p1 = 0; p2 = 0; any = 0; lu = 0;
      for (int k = 0; k < dep[i]; k++) begin
        h1 = mv[i][k] && mw[i][k] && (md[i][k] == src_1);
        h2 = two_src && mv[i][k] && mw[i][k] && (md[i][k] == src_2);
        if (h1 && p1 == 0) p1 = k + 1;
        if (h2 && p2 == 0) p2 = k + 1;
        if (h1 || h2) any = 1;
        if (k == 0 && mm[i][0] && (h1 || h2)) lu = 1;
      end
      mh[i]  = id_valid && (fen[i] ? lu : any);
      mf1[i] = (fen[i] && id_valid) ? p1 : 0;
      mf2[i] = (fen[i] && id_valid) ? p2 : 0;
    end
  endfunction

  function automatic void model_clock();
    for (int i = 0; i < 3; i++) begin
      bit iss;
      iss = id_valid && !mh[i] && !flush;
      if (mh[i]) begin
        if (mcnt[i] < 65535) mcnt[i]++;
        if (i == 2) raw2++;
      end
      for (int k = 7; k >= 1; k--) begin
        mv[i][k] = mv[i][k-1]; mw[i][k] = mw[i][k-1];
        mm[i][k] = mm[i][k-1]; md[i][k] = md[i][k-1];
      end
      mv[i][0] = iss;
      mw[i][0] = iss && id_wb_en;
      mm[i][0] = iss && id_mem_read;
      md[i][0] = iss ? id_dest : 4'd0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    model_eval();
    chk("u0_hazard", int'(haz_0), int'(mh[0]));
    chk("u0_fwd1",   int'(f1_0),  mf1[0]);
    chk("u0_fwd2",   int'(f2_0),  mf2[0]);
    chk("u0_count",  int'(cnt_0), mcnt[0]);
    chk("u1_hazard", int'(haz_1), int'(mh[1]));
    chk("u1_fwd1",   int'(f1_1),  mf1[1]);
    chk("u1_fwd2",   int'(f2_1),  mf2[1]);
    chk("u1_count",  int'(cnt_1), mcnt[1]);
    chk("u2_hazard", int'(haz_2), int'(mh[2]));
    chk("u2_fwd1",   int'(f1_2),  mf1[2]);
    chk("u2_fwd2",   int'(f2_2),  mf2[2]);
    chk("u2_count",  int'(cnt_2), mcnt[2]);
  endtask

  // Inputs are driven just after a rising edge; look() samples mid-cycle.
  task automatic look(input bit cmp);
    #2;
    if (cmp) compare_model();
    else     model_eval();
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       v;
    logic [3:0] s1, s2;
    logic       ts, wb;
    logic [3:0] dest;
    logic       mr, fl;
    logic       h0, h1;
    logic [1:0] f1, f2;
    int         c0;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                              input logic ts, input logic wb, input logic [3:0] dest,
                              input logic mr, input logic fl, input logic h0, input logic h1,
                              input logic [1:0] f1, input logic [1:0] f2, input int c0);
    vec_t r;
    r.v = v; r.s1 = s1; r.s2 = s2; r.ts = ts; r.wb = wb; r.dest = dest;
    r.mr = mr; r.fl = fl; r.h0 = h0; r.h1 = h1; r.f1 = f1; r.f2 = f2; r.c0 = c0;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic ts, input logic wb, input logic [3:0] dest,
                       input logic mr, input logic fl);
    id_valid = v; src_1 = s1; src_2 = s2; two_src = ts;
    id_wb_en = wb; id_dest = dest; id_mem_read = mr; flush = fl;
  endtask

  vec_t vecs [25];

  initial begin
    int guard;
    //            v  s1 s2 ts wb dst mr fl  h0 h1 f1 f2 c0
    vecs[0]  = mk(1, 0, 0, 0, 1, 3,  0, 0,  0, 0, 0, 0, 0); // ADD R3
    vecs[1]  = mk(1, 3, 0, 0, 1, 8,  0, 0,  1, 0, 1, 0, 0); // use R3
    vecs[2]  = mk(1, 3, 0, 0, 1, 8,  0, 0,  1, 0, 2, 0, 1);
    vecs[3]  = mk(1, 3, 0, 0, 1, 8,  0, 0,  0, 0, 0, 0, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 2);
    vecs[5]  = mk(1, 0, 0, 0, 1, 4,  0, 0,  0, 0, 0, 0, 2); // ADD R4
    vecs[6]  = mk(1, 4, 4, 1, 1, 9,  0, 0,  1, 0, 1, 1, 2); // SUB R4,R4
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 3);
    vecs[8]  = mk(1, 0, 0, 0, 1, 4,  0, 0,  0, 0, 0, 0, 3); // ADD R4
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 3); // bubble
    vecs[10] = mk(1, 4, 4, 1, 0, 0,  0, 0,  1, 0, 2, 2, 3);
    vecs[11] = mk(1, 0, 0, 0, 1, 5,  1, 0,  0, 0, 0, 0, 4); // LDR R5
    vecs[12] = mk(1, 5, 0, 0, 1, 10, 0, 0,  1, 1, 1, 0, 4); // load-use
    vecs[13] = mk(1, 5, 0, 0, 1, 10, 0, 0,  1, 0, 2, 0, 5);
    vecs[14] = mk(1, 5, 0, 0, 1, 10, 0, 0,  0, 0, 0, 0, 6);
    vecs[15] = mk(1, 0, 0, 0, 1, 5,  1, 0,  0, 0, 0, 0, 6); // LDR R5
    vecs[16] = mk(1, 0, 5, 0, 0, 0,  0, 0,  0, 0, 0, 0, 6); // src_2 unused
    vecs[17] = mk(1, 0, 0, 0, 1, 6,  0, 0,  0, 0, 0, 0, 6); // R6
    vecs[18] = mk(1, 0, 0, 0, 1, 6,  0, 0,  0, 0, 0, 0, 6); // R6 again
    vecs[19] = mk(1, 6, 0, 0, 0, 0,  0, 0,  1, 0, 1, 0, 6); // youngest
    vecs[20] = mk(1, 0, 0, 0, 0, 6,  0, 0,  0, 0, 0, 0, 7); // R6, no wb
    vecs[21] = mk(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 7);
    vecs[22] = mk(1, 6, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 7);
    vecs[23] = mk(1, 0, 0, 0, 1, 7,  0, 1,  0, 0, 0, 0, 7); // flushed R7
    vecs[24] = mk(1, 7, 7, 1, 0, 0,  0, 0,  0, 0, 0, 0, 7);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    compare_model();
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[r]) begin
      drive(vecs[r].v, vecs[r].s1, vecs[r].s2, vecs[r].ts, vecs[r].wb,
            vecs[r].dest, vecs[r].mr, vecs[r].fl);
      look(1'b1);
      chk($sformatf("vec%0d_haz_fwd0", r), int'(haz_0), int'(vecs[r].h0));
      chk($sformatf("vec%0d_haz_fwd1", r), int'(haz_1), int'(vecs[r].h1));
      chk($sformatf("vec%0d_sel1", r),     int'(f1_1),  int'(vecs[r].f1));
      chk($sformatf("vec%0d_sel2", r),     int'(f2_1),  int'(vecs[r].f2));
      chk($sformatf("vec%0d_count", r),    int'(cnt_0), vecs[r].c0);
      advance();
    end

    // Reset asserted while a load-use stall is active.
    for (int n = 0; n < 9; n++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      look(1'b1);
      advance();
    end
    drive(1, 0, 0, 0, 1, 2, 1, 0);
    look(1'b1);
    advance();
    drive(1, 2, 0, 0, 1, 11, 0, 0);
    look(1'b1);
    chk("pre_reset_haz", int'(haz_1), 1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("reset_haz_fwd1", int'(haz_1), 0);
    chk("reset_haz_fwd0", int'(haz_0), 0);
    chk("reset_count",    int'(cnt_0), 0);
    chk("reset_sel1",     int'(f1_1),  0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    look(1'b1);
    chk("post_reset_haz", int'(haz_1), 0);
    advance();

    // Random traffic over a small register range to provoke matches.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, 4'($urandom % 4), 4'($urandom % 4), 1'($urandom),
            1'($urandom), 4'($urandom % 4), ($urandom % 3) == 0, ($urandom % 8) == 0);
      look(1'b1);
      advance();
    end

    // Saturation: a self-dependent instruction keeps the DEPTH=8 unit stalling.
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 0, 1, 1, 0, 0);
    guard = 0;
    while (raw2 < 65535 && guard < 80000) begin
      look(1'b0);
      advance();
      guard++;
    end
    chk("count_at_65535", int'(cnt_2), 65535);
    guard = 0;
    while (raw2 < 65536 && guard < 20) begin
      look(1'b0);
      advance();
      guard++;
    end
    chk("count_saturated", int'(cnt_2), 65535);
    look(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
